// File: rtl/nq_apb_pkg.sv
// Shared types and defaults for the nq_apb data-memory APB master.
package nq_apb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } apb_state_t;

  localparam int ADDR_W_DEF = 6;
  localparam int DATA_W_DEF = 16;
  localparam int CNT_W      = 8;

endpackage

// File: rtl/nq_apb_timeout.sv
// ACCESS-phase wait counter; o_expired flags that TIMEOUT wait cycles have elapsed.
module nq_apb_timeout
  import nq_apb_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_wait,
  output logic o_expired
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] r_cnt;

  assign o_expired = (r_cnt == LIMIT);

  // Saturate at the limit so a held expiry can never wrap back to zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       r_cnt <= '0;
    else if (i_clear)              r_cnt <= '0;
    else if (i_wait && !o_expired) r_cnt <= r_cnt + 1'b1;
  end

endmodule

// File: rtl/nq_apb_data_master.sv
// Single-outstanding APB3 master between the memory stage and data memory.
// Optional ACCESS timeout enabled by defining NQ_APB_TIMEOUT_EN.
module nq_apb_data_master
  import nq_apb_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              stall,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  apb_state_t        r_state;
  logic              r_psel;
  logic              r_penable;
  logic              r_pwrite;
  logic [ADDR_W-1:0] r_paddr;
  logic [DATA_W-1:0] r_pwdata;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic              r_rsp_err;

  logic w_idle;
  logic w_to_expired;

  assign w_idle    = (r_state == ST_IDLE);
  assign req_ready = w_idle;
  assign stall     = !w_idle || req_valid;

  assign psel      = r_psel;
  assign penable   = r_penable;
  assign pwrite    = r_pwrite;
  assign paddr     = r_paddr;
  assign pwdata    = r_pwdata;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

`ifdef NQ_APB_TIMEOUT_EN
  nq_apb_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk       (clk),
    .rst       (rst),
    .i_clear   (r_state == ST_SETUP),
    .i_wait    ((r_state == ST_ACCESS) && !pready),
    .o_expired (w_to_expired)
  );
`else
  // TIMEOUT is legal only in 1..255, so this folds to a constant 0.
  assign w_to_expired = (TIMEOUT == 0);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_pwrite    <= 1'b0;
      r_paddr     <= '0;
      r_pwdata    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_pwrite <= req_write;
            r_paddr  <= req_addr;
            r_pwdata <= req_wdata;
            r_psel   <= 1'b1;
            r_state  <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          r_penable <= 1'b1;
          r_state   <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (pready) begin
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= pslverr;
            r_rsp_rdata <= (!r_pwrite && !pslverr) ? prdata : '0;
            r_state     <= ST_IDLE;
          end else if (w_to_expired) begin
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b1;
            r_rsp_rdata <= '0;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_psel    <= 1'b0;
          r_penable <= 1'b0;
          r_state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nq_apb_data_master.sv
// Directed bench for nq_apb_data_master; timeout expectations follow NQ_APB_TIMEOUT_EN.
module tb_nq_apb_data_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_write;
  logic [5:0]  req_addr;
  logic [15:0] req_wdata;
  logic        req_ready, stall, rsp_valid, rsp_err;
  logic [15:0] rsp_rdata;
  logic        psel, penable, pwrite;
  logic [5:0]  paddr;
  logic [15:0] pwdata, prdata;
  logic        pready, pslverr;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  nq_apb_data_master #(.ADDR_W(6), .DATA_W(16), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .stall(stall),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  task automatic test_reset();
    rst = 1'b1; req_valid = 0; req_write = 0; req_addr = '0; req_wdata = '0;
    prdata = '0; pready = 0; pslverr = 0;
    @(negedge clk);
    n_vec++; if ({psel, penable, pwrite, rsp_valid, rsp_err} !== 5'b0) begin n_err++;
      $display("FAIL reset_ctrl: got %b want 00000", {psel, penable, pwrite, rsp_valid, rsp_err}); end
    n_vec++; if ({paddr, pwdata, rsp_rdata} !== 38'h0) begin n_err++;
      $display("FAIL reset_data: got %h want 0", {paddr, pwdata, rsp_rdata}); end
    rst = 1'b0;
    @(negedge clk);
    n_vec++; if ({req_ready, stall} !== 2'b10) begin n_err++;
      $display("FAIL reset_ready_stall: got %b want 10", {req_ready, stall}); end
  endtask

  task automatic test_load();
    req_valid = 1; req_write = 0; req_addr = 6'h05; req_wdata = 16'h7777;
    #1;
    n_vec++; if ({req_ready, stall} !== 2'b11) begin n_err++;
      $display("FAIL ld_accept_cycle ready/stall: got %b want 11", {req_ready, stall}); end
    @(negedge clk); // t1 SETUP
    req_valid = 0; pready = 1; prdata = 16'hBEEF;
    #1;
    n_vec++; if ({psel, penable, pwrite, paddr, stall, req_ready} !== {1'b1, 1'b0, 1'b0, 6'h05, 1'b1, 1'b0}) begin n_err++;
      $display("FAIL ld_setup: got sel%b en%b wr%b a%h st%b rdy%b want sel1 en0 wr0 a05 st1 rdy0",
               psel, penable, pwrite, paddr, stall, req_ready); end
    @(negedge clk); // t2 ACCESS
    n_vec++; if ({psel, penable, rsp_valid} !== 3'b110) begin n_err++;
      $display("FAIL ld_access: got %b want 110", {psel, penable, rsp_valid}); end
    @(negedge clk); // t3 response
    pready = 0; prdata = 16'h0000;
    #1;
    n_vec++; if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 16'hBEEF}) begin n_err++;
      $display("FAIL ld_rsp: got v%b e%b d%h want v1 e0 dBEEF", rsp_valid, rsp_err, rsp_rdata); end
    n_vec++; if ({psel, penable, stall, req_ready} !== 4'b0001) begin n_err++;
      $display("FAIL ld_rsp_bus: got %b want 0001", {psel, penable, stall, req_ready}); end
    @(negedge clk);
    n_vec++; if ({rsp_valid, rsp_rdata} !== {1'b0, 16'hBEEF}) begin n_err++;
      $display("FAIL ld_rsp_hold: got v%b d%h want v0 dBEEF", rsp_valid, rsp_rdata); end
  endtask

  task automatic test_store_wait();
    req_valid = 1; req_write = 1; req_addr = 6'h3F; req_wdata = 16'h1234;
    @(negedge clk); // SETUP
    req_valid = 0; req_addr = 6'h00; req_wdata = 16'h0000; pready = 0; prdata = 16'hAAAA;
    for (int i = 1; i <= 5; i++) begin
      if (i == 5) pready = 1; // three waited ACCESS cycles, then ready
      #1;
      n_vec++; if ({psel, pwrite, paddr, pwdata, stall, rsp_valid} !== {1'b1, 1'b1, 6'h3F, 16'h1234, 1'b1, 1'b0}) begin n_err++;
        $display("FAIL st_hold_cyc%0d: got sel%b wr%b a%h d%h st%b v%b want sel1 wr1 a3F d1234 st1 v0",
                 i, psel, pwrite, paddr, pwdata, stall, rsp_valid); end
      n_vec++; if (penable !== (i != 1)) begin n_err++;
        $display("FAIL st_penable_cyc%0d: got %b want %b", i, penable, (i != 1)); end
      @(negedge clk);
    end
    pready = 0;
    #1;
    n_vec++; if ({rsp_valid, rsp_err, rsp_rdata, stall, psel} !== {1'b1, 1'b0, 16'h0000, 1'b0, 1'b0}) begin n_err++;
      $display("FAIL st_rsp: got v%b e%b d%h st%b sel%b want v1 e0 d0000 st0 sel0",
               rsp_valid, rsp_err, rsp_rdata, stall, psel); end
    n_vec++; if ({paddr, pwdata, pwrite} !== {6'h3F, 16'h1234, 1'b1}) begin n_err++;
      $display("FAIL st_idle_hold: got a%h d%h wr%b want a3F d1234 wr1", paddr, pwdata, pwrite); end
    @(negedge clk);
  endtask

  task automatic test_slverr();
    req_valid = 1; req_write = 0; req_addr = 6'h0A;
    @(negedge clk);
    req_valid = 0; pready = 1; pslverr = 1; prdata = 16'hFFFF;
    @(negedge clk);
    @(negedge clk);
    pready = 0; pslverr = 0;
    #1;
    n_vec++; if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b1, 16'h0000}) begin n_err++;
      $display("FAIL slverr_rsp: got v%b e%b d%h want v1 e1 d0000", rsp_valid, rsp_err, rsp_rdata); end
    @(negedge clk);
    n_vec++; if ({rsp_valid, rsp_err} !== 2'b01) begin n_err++;
      $display("FAIL slverr_pulse: got v%b e%b want v0 e1", rsp_valid, rsp_err); end
  endtask

  task automatic test_back_to_back();
    req_valid = 1; req_write = 0; req_addr = 6'h01;
    @(negedge clk); // first SETUP
    req_addr = 6'h02; pready = 1; prdata = 16'h1111;
    @(negedge clk); // first ACCESS
    n_vec++; if ({psel, penable, paddr} !== {1'b1, 1'b1, 6'h01}) begin n_err++;
      $display("FAIL b2b_access1: got sel%b en%b a%h want sel1 en1 a01", psel, penable, paddr); end
    @(negedge clk); // first response, second accept
    prdata = 16'h2222;
    #1;
    n_vec++; if ({rsp_valid, rsp_rdata, req_ready, stall} !== {1'b1, 16'h1111, 1'b1, 1'b1}) begin n_err++;
      $display("FAIL b2b_rsp1: got v%b d%h rdy%b st%b want v1 d1111 rdy1 st1", rsp_valid, rsp_rdata, req_ready, stall); end
    @(negedge clk); // second SETUP, no gap
    req_valid = 0;
    #1;
    n_vec++; if ({psel, penable, paddr, rsp_valid} !== {1'b1, 1'b0, 6'h02, 1'b0}) begin n_err++;
      $display("FAIL b2b_setup2: got sel%b en%b a%h v%b want sel1 en0 a02 v0", psel, penable, paddr, rsp_valid); end
    @(negedge clk);
    @(negedge clk);
    pready = 0;
    #1;
    n_vec++; if ({rsp_valid, rsp_rdata} !== {1'b1, 16'h2222}) begin n_err++;
      $display("FAIL b2b_rsp2: got v%b d%h want v1 d2222", rsp_valid, rsp_rdata); end
    @(negedge clk);
  endtask

  task automatic test_timeout();
    req_valid = 1; req_write = 0; req_addr = 6'h07;
    @(negedge clk); // SETUP
    req_valid = 0; pready = 0; prdata = 16'h5A5A;
`ifdef NQ_APB_TIMEOUT_EN
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); // ACCESS with count 0..4
      n_vec++; if ({psel, penable, rsp_valid} !== 3'b110) begin n_err++;
        $display("FAIL to_wait%0d: got %b want 110", i, {psel, penable, rsp_valid}); end
    end
    @(negedge clk);
    n_vec++; if ({rsp_valid, rsp_err, rsp_rdata, psel, penable} !== {1'b1, 1'b1, 16'h0000, 1'b0, 1'b0}) begin n_err++;
      $display("FAIL to_abort: got v%b e%b d%h sel%b en%b want v1 e1 d0000 sel0 en0",
               rsp_valid, rsp_err, rsp_rdata, psel, penable); end
`else
    begin
      int bad = 0;
      for (int i = 0; i < 100; i++) begin
        @(negedge clk);
        if ({psel, penable, rsp_valid, stall} !== 4'b1101) bad++;
      end
      n_vec++; if (bad != 0) begin n_err++;
        $display("FAIL to_stuck_access: got %0d bad cycles want 0", bad); end
    end
    pready = 1; prdata = 16'h1357;
    @(negedge clk);
    pready = 0;
    #1;
    n_vec++; if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 16'h1357}) begin n_err++;
      $display("FAIL to_late_rsp: got v%b e%b d%h want v1 e0 d1357", rsp_valid, rsp_err, rsp_rdata); end
`endif
    @(negedge clk);
  endtask

  task automatic test_reset_mid_access();
    req_valid = 1; req_write = 0; req_addr = 6'h11;
    @(negedge clk);
    req_valid = 0; pready = 0;
    @(negedge clk); // ACCESS
    n_vec++; if ({psel, penable} !== 2'b11) begin n_err++;
      $display("FAIL rst_pre_access: got %b want 11", {psel, penable}); end
    #2 rst = 1'b1;
    #1;
    n_vec++; if ({psel, penable, rsp_valid, rsp_rdata} !== {3'b000, 16'h0000}) begin n_err++;
      $display("FAIL rst_async: got sel%b en%b v%b d%h want 0 0 0 0000", psel, penable, rsp_valid, rsp_rdata); end
    pready = 1; prdata = 16'h4444;
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_vec++; if ({req_ready, stall} !== 2'b10) begin n_err++;
      $display("FAIL rst_release: got rdy%b st%b want rdy1 st0", req_ready, stall); end
    @(negedge clk);
    @(negedge clk);
    n_vec++; if ({rsp_valid, psel, rsp_rdata} !== {2'b00, 16'h0000}) begin n_err++;
      $display("FAIL rst_abandon: got v%b sel%b d%h want v0 sel0 d0000", rsp_valid, psel, rsp_rdata); end
    pready = 0;
  endtask

  initial begin
    test_reset();
    test_load();
    test_store_wait();
    test_slverr();
    test_back_to_back();
    test_timeout();
    test_reset_mid_access();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
